// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Serial line and received-byte bundle for uart_rx.
//                slave  = receiver side (consumes the line, drives results)
//                master = line driver / byte consumer side
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_if;
  logic       UART_RX;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport slave (
    input  UART_RX,
    output data,
    output valid,
    output frame_err,
    output busy
  );

  modport master (
    output UART_RX,
    input  data,
    input  valid,
    input  frame_err,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 100 kbaud 8N1 UART receiver. Two-flop synchronizer, falling
//                edge start detection (armed only after a genuine high),
//                mid-bit sampling, one-cycle valid / frame_err pulses.
//                Optional macro UART_RX_MAJORITY_EN: each sample point uses a
//                2-of-3 vote over the nominal cycle -1, 0 and +1.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int CLK_RATE_HZ   = 1000000,
  parameter int COUNTER_WIDTH = $clog2(CLK_RATE_HZ / 100000)
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam int CPB  = CLK_RATE_HZ / 100000;
  localparam int HALF = CPB / 2;
  localparam logic [COUNTER_WIDTH-1:0] CPB_M1  = COUNTER_WIDTH'(CPB - 1);
  localparam logic [COUNTER_WIDTH-1:0] HALF_M1 = COUNTER_WIDTH'(HALF - 1);

  generate
    if ((CPB < 4) || ((CPB - 1) >= (1 << COUNTER_WIDTH))) begin : g_cfg_check
      $error("uart_rx: CPB must be >= 4 and fit in COUNTER_WIDTH bits");
    end
  endgenerate

  typedef enum logic [1:0] {
    s_idle  = 2'd0,
    s_start = 2'd1,
    s_bit   = 2'd2,
    s_stop  = 2'd3
  } state_t;

  state_t                   state;
  logic [COUNTER_WIDTH-1:0] cnt;
  logic [2:0]               bit_idx;
  logic [7:0]               shreg;
  logic [7:0]               data_reg;
  logic                     valid_reg;
  logic                     frame_err_reg;
  logic                     busy_reg;
  logic                     stop_done;

  logic                     sync0;
  logic                     sync1;
  logic [1:0]               warm;
  logic                     armed;
  logic                     sample;

`ifdef UART_RX_MAJORITY_EN
  logic                     line_d;
`endif

  // Synchronizer plus "line was genuinely high last cycle" tracking; warm
  // masks the reset-forced ones until real line values reach sync1.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync0 <= 1'b1;
      sync1 <= 1'b1;
      warm  <= 2'b00;
      armed <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      line_d <= 1'b1;
`endif
    end else begin
      sync0 <= bus.UART_RX;
      sync1 <= sync0;
      warm  <= {warm[0], 1'b1};
      armed <= warm[1] & sync1;
`ifdef UART_RX_MAJORITY_EN
      line_d <= sync1;
`endif
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // sync0 already holds the value line takes next cycle, so the vote spans
  // nominal-1 .. nominal+1 without moving the decision cycle.
  assign sample = (sync0 & sync1) | (sync0 & line_d) | (sync1 & line_d);
`else
  assign sample = sync1;
`endif

  // Receive state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= s_idle;
      cnt           <= '0;
      bit_idx       <= 3'd0;
      shreg         <= 8'h00;
      data_reg      <= 8'h00;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      busy_reg      <= 1'b0;
      stop_done     <= 1'b0;
    end else begin
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      case (state)
        s_idle: begin
          if (armed && !sync1) begin
            state    <= s_start;
            cnt      <= '0;
            busy_reg <= 1'b1;
          end
        end
        s_start: begin
          if (cnt == HALF_M1) begin
            if (sample) begin
              // Start bit not low at its centre: glitch, drop it silently.
              state    <= s_idle;
              busy_reg <= 1'b0;
            end else begin
              cnt     <= '0;
              bit_idx <= 3'd0;
              state   <= s_bit;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        s_bit: begin
          if (cnt == CPB_M1) begin
            shreg <= {sample, shreg[7:1]};
            cnt   <= '0;
            if (bit_idx == 3'd7) begin
              state <= s_stop;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        s_stop: begin
          // Stay one extra cycle so busy covers the result pulse.
          if (stop_done) begin
            stop_done <= 1'b0;
            state     <= s_idle;
            busy_reg  <= 1'b0;
          end else if (cnt == CPB_M1) begin
            stop_done <= 1'b1;
            if (sample) begin
              data_reg  <= shreg;
              valid_reg <= 1'b1;
            end else begin
              frame_err_reg <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= s_idle;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data      = data_reg;
  assign bus.valid     = valid_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.busy      = busy_reg;

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_RATE_HZ, default 1000000, system clock frequency in Hz.
REQ-002 Parameter COUNTER_WIDTH, default $clog2(CLK_RATE_HZ / 100000), bit-period counter width.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 UART_RX  input  1  asynchronous serial line, idle high.
REQ-006 data  output  8  last correctly framed received byte.
REQ-007 valid  output  1  one-cycle pulse when data updates.
REQ-008 frame_err  output  1  one-cycle pulse when a stop bit samples low.
REQ-009 busy  output  1  high while a frame is in progress (states other than s_idle).

Function
REQ-010 Fixed line rate of 100000 baud; CPB = CLK_RATE_HZ / 100000; HALF = CPB / 2; CPB SHALL be at least 4.
REQ-011 UART_RX SHALL pass through a 2-flop synchronizer; "line" below means the synchronizer output.
REQ-012 Frame format: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high), no parity.
REQ-013 States: s_idle, s_start, s_bit, s_stop.
REQ-014 s_idle: detection cycle D is the first cycle where line is 0 and its previous-cycle value was 1; enter s_start and clear the counter.
REQ-015 A line held low, including a break or a line low out of reset, SHALL NOT trigger a start until it has been seen high.
REQ-016 s_start: sample line at D+HALF; if 1, treat as a glitch and return to s_idle with no output pulse; if 0, clear the counter and enter s_bit.
REQ-017 s_bit: data bit k (k = 0..7) is sampled at D+HALF+(k+1)*CPB and shifted into a shift register LSB first; after bit 7, enter s_stop.
REQ-018 s_stop: the stop bit is sampled at D+HALF+9*CPB.
REQ-019 Stop = 1: on the next cycle, data SHALL take the shift register value and valid SHALL pulse for exactly one cycle.
REQ-020 Stop = 0: on the next cycle, frame_err SHALL pulse for exactly one cycle and data SHALL hold its previous value.
REQ-021 Both paths return to s_idle.
REQ-022 valid and frame_err SHALL never be high in the same cycle.
REQ-023 A new start MAY be detected on the cycle after return to s_idle, so back-to-back frames are supported.
REQ-024 The counter SHALL wrap only via an explicit clear, never by overflow; COUNTER_WIDTH SHALL hold CPB-1.

Reset
REQ-025 While reset is high: state = s_idle, counter = 0, bit index = 0, shift register = 0, data = 8'h00, valid = 0, frame_err = 0, busy = 0, synchronizer flops = 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err pulse.
REQ-027 After reset deasserts, the next start requires a fresh high-to-low transition on line.

Configuration
REQ-028 Macro UART_RX_MAJORITY_EN.
REQ-029 When UART_RX_MAJORITY_EN is defined, every sample point (start, data, stop) SHALL use a 2-of-3 majority of line at the nominal sample cycle -1, 0 and +1; the decision timing is unchanged.
REQ-030 When UART_RX_MAJORITY_EN is undefined, each sample point uses the single line value at the nominal cycle.

Verification (CLK_RATE_HZ = 1000000, CPB = 10, HALF = 5)
REQ-031 Send byte 0xA5 at 100 kbaud -> a single valid pulse at D+96, data = 0xA5, frame_err stays 0, busy high from D+1 to D+96.
REQ-032 Send 0x3C with the stop bit forced low -> a frame_err pulse at D+96, data keeps its prior value, no valid pulse.
REQ-033 Drive a 3-cycle low glitch on idle line -> return to s_idle at D+5, no valid or frame_err pulse, busy low again by D+6.
REQ-034 Send 0x00 then 0xFF back-to-back with no idle gap -> two valid pulses 100 cycles apart, with data 0x00 then 0xFF.
REQ-035 Assert reset during data bit 3 of a frame, then hold the line low -> no output pulse, and no start until the line goes high then low.
REQ-036 With UART_RX_MAJORITY_EN defined, inject a 1-cycle inverted glitch at a data-bit sample point of 0x55 -> valid with data = 0x55.
